countdown_timer: RTL

// - Loadable down-counter: the decrementing counterpart to the free-running up counter in the same design.
// - Accepts a start value over a valid/ready load handshake and decrements once per enabled cycle.
// - Emits a one-cycle expiry pulse when the count reaches zero.
// - Sits beside the counter/adder datapath as the timeout/interval source for top-level control.

---
 rtl/countdown_timer_pkg.sv | 11 +
 rtl/countdown_timer.sv | 103 ++++++++++
 2 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package countdown_timer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1
   } state_t;

endpackage : countdown_timer_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle expiry pulse; load is a valid/ready handshake.
// Optional macro COUNTDOWN_TIMER_AUTO_RELOAD_EN turns it into a periodic interval source.
//
// Handshake: a load is accepted on a rising edge where load_valid && load_ready;
// load_ready is high exactly in IDLE, and load_value is sampled only on that edge.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_value,
   output logic             load_ready,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             expired
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             expired_q, expired_d;
   logic             load_fire;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   assign load_ready = (state_q == IDLE);
   assign busy       = (state_q == RUN);
   assign count      = count_q;
   assign expired    = expired_q;
   assign load_fire  = load_valid && load_ready;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      expired_d = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_d  = reload_q;
`endif
      case (state_q)
         IDLE: begin
            if (load_fire) begin
               count_d = load_value;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
               reload_d = load_value;
`endif
               // A zero load expires immediately without ever running.
               if (load_value == '0) begin
                  expired_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (abort) begin
               count_d = '0;
               state_d = IDLE;
            end else if (enable) begin
               if (count_q == WIDTH'(1)) begin
                  expired_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                  count_d   = reload_q;
`else
                  count_d   = '0;
                  state_d   = IDLE;
`endif
               end else begin
                  count_d = count_q - WIDTH'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         expired_q <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
         reload_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         expired_q <= expired_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
         reload_q  <= reload_d;
`endif
      end
   end

endmodule : countdown_timer
